uart_tx_buffered: RTL and testbench

Parametrised successor to the core's single-byte UART transmitter, sitting behind the memory-mapped UART register block.
- Accepts characters through a valid/ready write port into an internal FIFO.
- Serialises characters LSB-first with configurable data width, parity and stop bits.
- Sends back-to-back frames with no idle gap, so firmware no longer polls tx_data_ready per byte.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_buffered.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and the
// bit-period helper used by the TX path (and later the RX path).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  function automatic int unsigned baud_cycles(input int unsigned clk_hz,
                                              input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is refused even
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, gapless back-to-back frames.
// Optional UART_TX_CTS_EN adds a synchronised active-low cts_n gate on pops.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned CYCLE = baud_cycles(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (CYCLE < 2) ? 1 : $clog2(CYCLE);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_START = 3'(START);
  localparam logic [2:0] ST_DATA  = 3'(DATA);
  localparam logic [2:0] ST_PAR   = 3'(PAR);
  localparam logic [2:0] ST_STOP  = 3'(STOP);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  if (CYCLE < 2) begin : g_bad_cycle
    $error("uart_tx_buffered: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_buffered: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 head_par, cts_ok, can_pop, bit_end, load;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (wr_valid),
    .wr_data_i (wr_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

`ifdef UART_TX_CTS_EN
  logic cts_s1_q, cts_s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign cts_ok = !cts_s2_q;
`else
  assign cts_ok = 1'b1;
`endif

  assign can_pop  = !fifo_empty && cts_ok;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign head_par = (PARITY == int'(PAR_ODD)) ? ~^fifo_head : ^fifo_head;

  always_comb begin
    // NOTE: every _d gets a default first so no branch can infer a latch.
    state_d  = state_q;
    cnt_d    = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_pop) load = 1'b1;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_DATA) begin
          bit_d = '0;
          if (PARITY != 0) begin
            state_d = ST_PAR;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = shift_q[1];
        end
      end
      ST_PAR: if (bit_end) begin
        state_d = ST_STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      ST_STOP: if (bit_end) begin
        if (bit_q != LAST_STOP) begin
          bit_d = bit_q + 3'd1;
        end else if (can_pop) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // The start bit goes out on the same edge that pops the character.
    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = fifo_head;
      par_d   = head_par;
      tx_d    = 1'b0;
    end
  end

  assign fifo_pop   = load;
  assign overflow_d = overflow_q | (wr_valid & fifo_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign wr_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at CYCLE=4: four instances cover
// 8N1, 8E1, 8O1 and 7O2; a line monitor per instance decodes frames.
module tb_uart_tx_buffered;

  localparam int CYC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] wd_a, wd_e, wd_o;
  logic [6:0] wd_7;
  logic       wv_a, wv_e, wv_o, wv_7;
  logic       rdy_a, rdy_e, rdy_o, rdy_7;
  logic       tx_a, tx_e, tx_o, tx_7;
  logic       busy_a, busy_e, busy_o, busy_7;
  logic       ovf_a, ovf_e, ovf_o, ovf_7;
  logic [2:0] cnt_a, cnt_e, cnt_o, cnt_7;
`ifdef UART_TX_CTS_EN
  logic       cts_a;
`endif

  uart_tx_buffered #(.CLK_HZ(4), .BAUD(1), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_a),
`endif
    .wr_data(wd_a), .wr_valid(wv_a), .wr_ready(rdy_a), .tx(tx_a),
    .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a));

  uart_tx_buffered #(.CLK_HZ(4), .BAUD(1), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_CTS_EN
    .cts_n(1'b0),
`endif
    .wr_data(wd_e), .wr_valid(wv_e), .wr_ready(rdy_e), .tx(tx_e),
    .busy(busy_e), .fifo_count(cnt_e), .overflow(ovf_e));

  uart_tx_buffered #(.CLK_HZ(4), .BAUD(1), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_CTS_EN
    .cts_n(1'b0),
`endif
    .wr_data(wd_o), .wr_valid(wv_o), .wr_ready(rdy_o), .tx(tx_o),
    .busy(busy_o), .fifo_count(cnt_o), .overflow(ovf_o));

  uart_tx_buffered #(.CLK_HZ(4), .BAUD(1), .DATA_BITS(7), .PARITY(2),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_7 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_CTS_EN
    .cts_n(1'b0),
`endif
    .wr_data(wd_7), .wr_valid(wv_7), .wr_ready(rdy_7), .tx(tx_7),
    .busy(busy_7), .fifo_count(cnt_7), .overflow(ovf_7));

  wire [3:0] tx_bus = {tx_7, tx_o, tx_e, tx_a};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected frames, bit i = i-th bit on the line (start bit first).
  logic [11:0] q0[$], q1[$], q2[$], q3[$];

  task automatic sb_push(input int idx, input logic [11:0] f);
    case (idx)
      0: q0.push_back(f);
      1: q1.push_back(f);
      2: q2.push_back(f);
      default: q3.push_back(f);
    endcase
  endtask

  function automatic int sb_size(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [11:0] sb_pop(input int idx);
    case (idx)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Decodes one frame from a falling start edge; each bit must hold CYC clocks.
  task automatic monitor(input int idx, input int nbits);
    logic [11:0] got;
    logic [11:0] exp;
    bit          glitch;
    bit          abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_bus[idx] === 1'b0) begin
        got    = '0;
        glitch = 1'b0;
        abort  = 1'b0;
        for (int j = 0; j < nbits && !abort; j++) begin
          for (int c = 0; c < CYC && !abort; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1)          abort  = 1'b1;
            else if (c == 0)             got[j] = tx_bus[idx];
            else if (tx_bus[idx] !== got[j]) glitch = 1'b1;
          end
        end
        if (!abort) begin
          if (sb_size(idx) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame[%0d]: got %0h expected none", idx, got);
          end else begin
            exp = sb_pop(idx);
            check($sformatf("frame[%0d]", idx), 32'(got), 32'(exp));
            check($sformatf("bit_hold[%0d]", idx), 32'(glitch), 32'd0);
          end
        end
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 11);
  initial monitor(2, 11);
  initial monitor(3, 11);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] d);
    return 12'({1'b1, d, 1'b0});
  endfunction

  logic [7:0] ovf_data [8];
  logic [2:0] exp_cnt  [8];
  logic       exp_rdy  [8];
  logic       exp_ovf  [8];

  initial begin
    rst_n = 1'b0;
    {wv_a, wv_e, wv_o, wv_7} = '0;
    wd_a = '0; wd_e = '0; wd_o = '0; wd_7 = '0;
`ifdef UART_TX_CTS_EN
    cts_a = 1'b0;
`endif
    tick(3);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_ready", 32'(rdy_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Single 0x5A, 8N1: line bits 0,0,1,0,1,1,0,1,0,1.
    wd_a = 8'h5A; wv_a = 1'b1; sb_push(0, 12'h2B4);
    tick(1);
    wv_a = 1'b0;
    check("t1_count", 32'(cnt_a), 32'd1);
    check("t1_idle_tx", 32'(tx_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd1);
    tick(1);
    check("t1_start_latency", 32'(tx_a), 32'd0);
    tick(39);
    check("t1_busy_in_stop", 32'(busy_a), 32'd1);
    tick(1);
    check("t1_busy_end", 32'(busy_a), 32'd0);
    tick(3);

    // Three back-to-back characters; second push coincides with first pop.
    wd_a = 8'h5A; wv_a = 1'b1; sb_push(0, f8n1(8'h5A));
    tick(1);
    check("t2_count_a", 32'(cnt_a), 32'd1);
    wd_a = 8'hA5; sb_push(0, f8n1(8'hA5));
    tick(1);
    check("t2_count_b", 32'(cnt_a), 32'd1);
    wd_a = 8'hFF; sb_push(0, f8n1(8'hFF));
    tick(1);
    wv_a = 1'b0;
    check("t2_count_c", 32'(cnt_a), 32'd2);
    tick(39);
    check("t2_gapless_1", 32'(tx_a), 32'd0);
    check("t2_count_d", 32'(cnt_a), 32'd1);
    tick(40);
    check("t2_gapless_2", 32'(tx_a), 32'd0);
    check("t2_count_e", 32'(cnt_a), 32'd0);
    tick(39);
    check("t2_busy_119", 32'(busy_a), 32'd1);
    tick(1);
    check("t2_busy_120", 32'(busy_a), 32'd0);
    tick(3);

    // Depth-4 overflow: 8 held writes, 5 accepted (first one pops at once).
    ovf_data = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    exp_cnt  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      wd_a = ovf_data[i];
      wv_a = 1'b1;
      if (i < 5) sb_push(0, f8n1(ovf_data[i]));
      tick(1);
      check($sformatf("t3_count_%0d", i), 32'(cnt_a), 32'(exp_cnt[i]));
      check($sformatf("t3_ready_%0d", i), 32'(rdy_a), 32'(exp_rdy[i]));
      check($sformatf("t3_ovf_%0d", i), 32'(ovf_a), 32'(exp_ovf[i]));
    end
    wv_a = 1'b0;
    tick(205);
    check("t3_ovf_sticky", 32'(ovf_a), 32'd1);
    check("t3_drained", 32'(cnt_a), 32'd0);
    check("t3_idle", 32'(busy_a), 32'd0);

    // Reset during data bit 3 of 0x5A (bit 3 = 1); the aborted frame is not expected.
    wd_a = 8'h5A; wv_a = 1'b1;
    tick(1);
    wv_a = 1'b0;
    tick(18);
    check("t4_data_bit3", 32'(tx_a), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("t4_rst_tx", 32'(tx_a), 32'd1);
    check("t4_rst_count", 32'(cnt_a), 32'd0);
    check("t4_rst_ovf", 32'(ovf_a), 32'd0);
    check("t4_rst_busy", 32'(busy_a), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    wd_a = 8'hC3; wv_a = 1'b1; sb_push(0, f8n1(8'hC3));
    tick(1);
    wv_a = 1'b0;
    tick(45);
    check("t4_after_rst_idle", 32'(busy_a), 32'd0);

    // Parity: 0x5A even -> 0, odd -> 1; 7O2 0x7F -> parity 0, two stop bits.
    wd_e = 8'h5A; wv_e = 1'b1; sb_push(1, 12'({1'b1, 1'b0, 8'h5A, 1'b0}));
    wd_o = 8'h5A; wv_o = 1'b1; sb_push(2, 12'({1'b1, 1'b1, 8'h5A, 1'b0}));
    wd_7 = 7'h7F; wv_7 = 1'b1; sb_push(3, 12'({2'b11, 1'b0, 7'h7F, 1'b0}));
    tick(1);
    {wv_e, wv_o, wv_7} = '0;
    tick(44);
    check("t5_busy7_in_stop", 32'(busy_7), 32'd1);
    tick(1);
    check("t5_busy7_end", 32'(busy_7), 32'd0);
    check("t5_busy_e_end", 32'(busy_e), 32'd0);
    tick(3);

`ifdef UART_TX_CTS_EN
    // Flow control: held off while cts_n=1, start 3 cycles after release.
    cts_a = 1'b1;
    tick(3);
    wd_a = 8'h41; wv_a = 1'b1; sb_push(0, f8n1(8'h41));
    tick(1);
    wv_a = 1'b0;
    tick(10);
    check("t6_held_tx", 32'(tx_a), 32'd1);
    check("t6_held_count", 32'(cnt_a), 32'd1);
    check("t6_held_busy", 32'(busy_a), 32'd1);
    cts_a = 1'b0;
    tick(1);
    check("t6_sync_1", 32'(tx_a), 32'd1);
    tick(1);
    check("t6_sync_2", 32'(tx_a), 32'd1);
    tick(1);
    check("t6_start", 32'(tx_a), 32'd0);
    tick(10);
    cts_a = 1'b1;
    tick(40);
    check("t6_complete", 32'(busy_a), 32'd0);
    cts_a = 1'b0;
`endif

    for (int i = 0; i < 200 && (q0.size() + q1.size() + q2.size() + q3.size()) != 0; i++)
      @(negedge clk);
    check("sb_empty_0", 32'(q0.size()), 32'd0);
    check("sb_empty_1", 32'(q1.size()), 32'd0);
    check("sb_empty_2", 32'(q2.size()), 32'd0);
    check("sb_empty_3", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
